ls_exec_queue: RTL and testbench

//  Parametrised load/store execution unit; sits between the LSB and the memory controller (MC).

---
 rtl/ls_exec_queue_if.sv | 51 +++++
 rtl/ls_exec_queue.sv | 173 +++++++++++++++++
 tb/tb_ls_exec_queue.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_exec_queue_if.sv
// Purpose: groups the LSB-side push port, the memory-controller request/response
//          port, the CDB broadcast and the rdy/rollback controls of ls_exec_queue.
// Modports:
//   slave  - the execution queue itself (consumes ops and MC responses, drives
//            in_ready, MC requests and CDB results)
//   master - the surrounding pipeline / memory controller view
interface ls_exec_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              rdy;
  logic              rollback;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;

  logic              mc_req;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_wr;
  logic [2:0]        mc_size;
  logic              mc_ok;
  logic [DATA_W-1:0] mc_rdata;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_result;

  modport slave (
    input  rdy, rollback,
    input  in_valid, in_op, in_addr, in_data, in_tag,
    output in_ready,
    output mc_req, mc_addr, mc_wdata, mc_wr, mc_size,
    input  mc_ok, mc_rdata,
    output cdb_valid, cdb_tag, cdb_result
  );

  modport master (
    output rdy, rollback,
    output in_valid, in_op, in_addr, in_data, in_tag,
    input  in_ready,
    input  mc_req, mc_addr, mc_wdata, mc_wr, mc_size,
    output mc_ok, mc_rdata,
    input  cdb_valid, cdb_tag, cdb_result
  );
endinterface

// File: rtl/ls_exec_queue.sv
// Purpose: in-order load/store execution queue between the LSB and the memory
//          controller. Buffers up to QDEPTH ops, issues one at a time, extends
//          load data and broadcasts load results on the CDB. Rollback squashes
//          queued/in-flight loads while stores always complete.
// Ports:
//   clk - clock
//   rst - synchronous, active-high reset
//   bus - ls_exec_queue_if.slave (rdy, rollback, LSB push, MC request/response, CDB)
//
// State  | meaning
// S_IDLE | no MC transaction outstanding; pop head (issue if live)
// S_WAIT | one MC transaction outstanding; wait for mc_ok
module ls_exec_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int QDEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  ls_exec_queue_if.slave bus
);
  localparam int PTR_W = $clog2(QDEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [QDEPTH-1:0] r_live;
  logic [3:0]        r_op   [QDEPTH];
  logic [ADDR_W-1:0] r_addr [QDEPTH];
  logic [DATA_W-1:0] r_data [QDEPTH];
  logic [TAG_W-1:0]  r_tag  [QDEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic              r_drop;
  logic [3:0]        r_fl_op;
  logic [TAG_W-1:0]  r_fl_tag;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_head_live;
  logic              w_cdb_fire;
  logic [2:0]        w_size;
  logic [DATA_W-1:0] w_ext;

  assign w_empty     = (r_count == '0);
  assign bus.in_ready = (r_count < (PTR_W+1)'(QDEPTH));
  assign w_push      = bus.in_valid & bus.in_ready & bus.rdy;
  // A load at the head is squashed by a rollback sampled on the same edge,
  // so it is popped without reaching the MC.
  assign w_head_live = r_live[r_head] & ~(bus.rollback & ~r_op[r_head][2]);

  always_comb begin
    case (r_op[r_head][1:0])
      2'd0:    w_size = 3'd1;
      2'd1:    w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  always_comb begin
    case (r_fl_op[1:0])
      2'd0: w_ext = r_fl_op[3] ? {{(DATA_W-8){1'b0}}, bus.mc_rdata[7:0]}
                               : {{(DATA_W-8){bus.mc_rdata[7]}}, bus.mc_rdata[7:0]};
      2'd1: w_ext = r_fl_op[3] ? {{(DATA_W-16){1'b0}}, bus.mc_rdata[15:0]}
                               : {{(DATA_W-16){bus.mc_rdata[15]}}, bus.mc_rdata[15:0]};
      default: w_ext = bus.mc_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst)          r_state <= S_IDLE;
    else if (bus.rdy) r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue)    w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mc_ok)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs (registered below under rdy)
  always_comb begin
    w_pop      = 1'b0;
    w_issue    = 1'b0;
    w_cdb_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop   = ~w_empty & bus.rdy;
        w_issue = ~w_empty & w_head_live;
      end
      S_WAIT: w_cdb_fire = bus.mc_ok & ~r_fl_op[2] & ~r_drop & ~bus.rollback;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_live  <= '0;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        for (int i = 0; i < QDEPTH; i++)
          if (!r_op[i][2]) r_live[i] <= 1'b0;
      end
      // Later assignment wins: a same-cycle load push lands dead, a store live.
      if (w_push) begin
        r_live[r_tail] <= bus.in_op[2] | ~bus.rollback;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op[r_tail]   <= bus.in_op;
      r_addr[r_tail] <= bus.in_addr;
      r_data[r_tail] <= bus.in_data;
      r_tag[r_tail]  <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mc_req     <= 1'b0;
      bus.mc_addr    <= '0;
      bus.mc_wdata   <= '0;
      bus.mc_wr      <= 1'b0;
      bus.mc_size    <= 3'd0;
      bus.cdb_valid  <= 1'b0;
      bus.cdb_tag    <= '0;
      bus.cdb_result <= '0;
      r_fl_op        <= 4'd0;
      r_fl_tag       <= '0;
      r_drop         <= 1'b0;
    end else if (bus.rdy) begin
      bus.mc_req <= w_issue;
      if (w_issue) begin
        bus.mc_addr  <= r_addr[r_head];
        bus.mc_wdata <= r_data[r_head];
        bus.mc_wr    <= r_op[r_head][2];
        bus.mc_size  <= w_size;
        r_fl_op      <= r_op[r_head];
        r_fl_tag     <= r_tag[r_head];
      end
      // The MC transaction always completes; drop only suppresses its result.
      if (r_state == S_WAIT && bus.mc_ok)
        r_drop <= 1'b0;
      else if (r_state == S_WAIT && bus.rollback && !r_fl_op[2])
        r_drop <= 1'b1;
      bus.cdb_valid <= w_cdb_fire;
      if (w_cdb_fire) begin
        bus.cdb_tag    <= r_fl_tag;
        bus.cdb_result <= w_ext;
      end
    end
  end
endmodule

// File: tb/tb_ls_exec_queue.sv
module tb_ls_exec_queue;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ls_exec_queue_if #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) bus();

  ls_exec_queue #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .QDEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          live;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
  } ent_t;

  // Reference model: ops waiting in the queue, plus the one at the MC.
  ent_t        m_q[$];
  ent_t        m_fl;
  bit          m_infl = 1'b0;
  bit          m_drop = 1'b0;
  bit          exp_cdb = 1'b0;
  logic [3:0]  exp_tag = 4'd0;
  logic [31:0] exp_res = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [3:0] op);
    case (op[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] exp_ext(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] v;
    case (op[1:0])
      2'd0: begin
        v = d & 32'h0000_00FF;
        if (!op[3] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = d & 32'h0000_FFFF;
        if (!op[3] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic clr_in();
    bus.in_valid = 1'b0;
    bus.in_op    = 4'd0;
    bus.in_addr  = 32'd0;
    bus.in_data  = 32'd0;
    bus.in_tag   = 4'd0;
  endtask

  task automatic put(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_tag   = t;
  endtask

  // One clock edge: capture inputs, advance the model, sample #1 after the edge.
  task automatic tick();
    bit          e_rst, e_rdy, e_rb, e_ok, e_push;
    ent_t        e_ent;
    logic [31:0] e_rdata;
    e_rst   = rst;
    e_rdy   = bus.rdy;
    e_rb    = bus.rollback;
    e_ok    = bus.mc_ok;
    e_push  = bus.in_valid && bus.in_ready && bus.rdy;
    e_rdata = bus.mc_rdata;
    e_ent.op   = bus.in_op;
    e_ent.addr = bus.in_addr;
    e_ent.data = bus.in_data;
    e_ent.tag  = bus.in_tag;
    e_ent.live = bus.in_op[2] || !bus.rollback;
    @(posedge clk);
    #1;
    if (e_rst) begin
      m_q.delete();
      m_infl  = 1'b0;
      m_drop  = 1'b0;
      exp_cdb = 1'b0;
      return;
    end
    if (!e_rdy) return;
    if (e_rb) begin
      foreach (m_q[i]) if (!m_q[i].op[2]) m_q[i].live = 1'b0;
      if (m_infl && !m_fl.op[2] && !e_ok) m_drop = 1'b1;
    end
    exp_cdb = 1'b0;
    if (e_ok && m_infl) begin
      if (!m_fl.op[2] && !m_drop && !e_rb) begin
        exp_cdb = 1'b1;
        exp_tag = m_fl.tag;
        exp_res = exp_ext(m_fl.op, e_rdata);
      end
      m_infl = 1'b0;
      m_drop = 1'b0;
    end
    if (e_push) m_q.push_back(e_ent);

    chk("cdb_valid", 32'(bus.cdb_valid), 32'(exp_cdb));
    if (exp_cdb) begin
      chk("cdb_tag", 32'(bus.cdb_tag), 32'(exp_tag));
      chk("cdb_result", bus.cdb_result, exp_res);
    end
    if (bus.mc_req === 1'b1) begin
      while (m_q.size() > 0 && !m_q[0].live) void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        chk("unexpected_mc_req", 32'(bus.mc_req), 32'd0);
      end else begin
        m_fl   = m_q.pop_front();
        m_infl = 1'b1;
        chk("mc_addr", bus.mc_addr, m_fl.addr);
        chk("mc_wr", 32'(bus.mc_wr), 32'(m_fl.op[2]));
        chk("mc_size", 32'(bus.mc_size), 32'(exp_size(m_fl.op)));
        if (m_fl.op[2]) chk("mc_wdata", bus.mc_wdata, m_fl.data);
      end
    end
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (bus.mc_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.mc_req), 32'd1);
  endtask

  task automatic complete(input logic [31:0] rd);
    bus.mc_ok    = 1'b1;
    bus.mc_rdata = rd;
    tick();
    bus.mc_ok    = 1'b0;
  endtask

  initial begin
    int pend;
    int live_left;

    bus.rdy      = 1'b1;
    bus.rollback = 1'b0;
    bus.mc_ok    = 1'b0;
    bus.mc_rdata = 32'd0;
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mc_req", 32'(bus.mc_req), 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'd0);
    chk("rst_mc_wdata", bus.mc_wdata, 32'd0);
    chk("rst_mc_wr", 32'(bus.mc_wr), 32'd0);
    chk("rst_mc_size", 32'(bus.mc_size), 32'd0);
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
    chk("rst_cdb_result", bus.cdb_result, 32'd0);

    // LB sign extension and issue latency
    put(4'b0000, 32'h10, 32'd0, 4'd5);
    tick();
    clr_in();
    tick();
    chk("t1_req_n_plus_1", 32'(bus.mc_req), 32'd1);
    chk("t1_size", 32'(bus.mc_size), 32'd1);
    chk("t1_wr", 32'(bus.mc_wr), 32'd0);
    complete(32'h0000_0080);
    chk("t1_cdb_valid", 32'(bus.cdb_valid), 32'd1);
    chk("t1_cdb_result", bus.cdb_result, 32'hFFFF_FF80);
    chk("t1_cdb_tag", 32'(bus.cdb_tag), 32'd5);
    tick();
    chk("t1_cdb_one_cycle", 32'(bus.cdb_valid), 32'd0);

    // LHU then LBU
    put(4'b1001, 32'h20, 32'd0, 4'd1);
    tick();
    put(4'b1000, 32'h21, 32'd0, 4'd2);
    tick();
    clr_in();
    chk("t2_req_lhu", 32'(bus.mc_req), 32'd1);
    chk("t2_size_lhu", 32'(bus.mc_size), 32'd2);
    complete(32'hABCD_8F80);
    chk("t2_res_lhu", bus.cdb_result, 32'h0000_8F80);
    chk("t2_tag_lhu", 32'(bus.cdb_tag), 32'd1);
    wait_req("t2_req_lbu", 5);
    chk("t2_size_lbu", 32'(bus.mc_size), 32'd1);
    complete(32'hABCD_8F80);
    chk("t2_res_lbu", bus.cdb_result, 32'h0000_0080);
    chk("t2_tag_lbu", 32'(bus.cdb_tag), 32'd2);

    // Fill: one store in flight, four queued
    for (int i = 0; i < 5; i++) begin
      put(4'b0110, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'd0);
      tick();
    end
    clr_in();
    chk("t3_full", 32'(bus.in_ready), 32'd0);
    complete(32'd0);
    chk("t3_full_after_ok", 32'(bus.in_ready), 32'd0);
    put(4'b0110, 32'h114, 32'hA5, 4'd0);
    tick();
    chk("t3_prepop_ready", 32'(bus.in_ready), 32'd1);
    chk("t3_req_next", 32'(bus.mc_req), 32'd1);
    tick();
    clr_in();
    chk("t3_full_again", 32'(bus.in_ready), 32'd0);
    complete(32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_req("t3_drain_req", 5);
      complete(32'd0);
    end
    chk("t3_wrap_last_addr", bus.mc_addr, 32'h114);

    // Rollback while SW in flight
    put(4'b0110, 32'h20, 32'h1234, 4'd0);
    tick();
    put(4'b0010, 32'h30, 32'd0, 4'd9);
    tick();
    put(4'b0100, 32'h40, 32'h55, 4'd0);
    tick();
    clr_in();
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    complete(32'd0);
    tick();
    chk("t4_lw_skipped", 32'(bus.mc_req), 32'd0);
    tick();
    chk("t4_sb_req", 32'(bus.mc_req), 32'd1);
    chk("t4_sb_addr", bus.mc_addr, 32'h40);
    chk("t4_sb_size", 32'(bus.mc_size), 32'd1);
    complete(32'd0);
    tick();

    // Rollback with LW in flight, mc_ok three cycles later
    put(4'b0010, 32'h50, 32'd0, 4'd7);
    tick();
    put(4'b0110, 32'h60, 32'hBEEF, 4'd0);
    tick();
    clr_in();
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    tick();
    tick();
    complete(32'hDEAD_BEEF);
    chk("t5_no_cdb", 32'(bus.cdb_valid), 32'd0);
    tick();
    chk("t5_store_next", 32'(bus.mc_req), 32'd1);
    chk("t5_store_wr", 32'(bus.mc_wr), 32'd1);
    complete(32'd0);
    tick();

    // rdy freeze
    put(4'b0000, 32'h70, 32'd0, 4'd3);
    tick();
    clr_in();
    bus.rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_frozen_req", 32'(bus.mc_req), 32'd0);
      chk("t6_frozen_cdb_result", bus.cdb_result, 32'h0000_0080);
    end
    chk("t6_frozen_cdb_tag", 32'(bus.cdb_tag), 32'd2);
    bus.rdy = 1'b1;
    tick();
    chk("t6_resume_req", 32'(bus.mc_req), 32'd1);
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_req_held", 32'(bus.mc_req), 32'd1);
    end
    bus.rdy = 1'b1;
    complete(32'h0000_007F);
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_cdb_held", 32'(bus.cdb_valid), 32'd1);
      chk("t6_cdb_res_held", bus.cdb_result, 32'h0000_007F);
    end
    bus.rdy = 1'b1;
    tick();

    // Randomised traffic with rollbacks and variable MC latency
    pend = -1;
    for (int c = 0; c < 600; c++) begin
      bus.mc_ok = 1'b0;
      if (pend == 0) begin
        bus.mc_ok    = 1'b1;
        bus.mc_rdata = $urandom();
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      bus.rollback = ($urandom_range(0, 15) == 0);
      if (c < 500 && bus.in_ready && $urandom_range(0, 2) != 0)
        put(4'($urandom_range(0, 15)), $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      else
        clr_in();
      tick();
      if (bus.mc_req === 1'b1) pend = $urandom_range(0, 3);
    end
    bus.mc_ok    = 1'b0;
    bus.rollback = 1'b0;
    clr_in();
    live_left = 0;
    foreach (m_q[i]) if (m_q[i].live) live_left++;
    chk("rand_live_left", 32'(live_left), 32'd0);
    chk("rand_inflight_left", 32'(m_infl), 32'd0);

    // Reset in WAIT
    put(4'b0010, 32'h80, 32'd0, 4'd1);
    tick();
    clr_in();
    tick();
    chk("t7_in_wait", 32'(bus.mc_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_mc_req", 32'(bus.mc_req), 32'd0);
    chk("t7_mc_addr", bus.mc_addr, 32'd0);
    chk("t7_mc_size", 32'(bus.mc_size), 32'd0);
    chk("t7_mc_wr", 32'(bus.mc_wr), 32'd0);
    chk("t7_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("t7_cdb_result", bus.cdb_result, 32'd0);
    chk("t7_cdb_tag", 32'(bus.cdb_tag), 32'd0);
    chk("t7_in_ready", 32'(bus.in_ready), 32'd1);
    put(4'b0110, 32'h90, 32'd5, 4'd0);
    tick();
    clr_in();
    wait_req("t7_post_rst_req", 4);
    chk("t7_post_rst_addr", bus.mc_addr, 32'h90);
    complete(32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
